// File: rtl/neuron_mac_ctrl_if.sv
// Handshake and data bundle between the neuron MAC stage, its input
// source and the upstream "old value" multiplexer.
interface neuron_mac_ctrl_if #(
  parameter int XW = 7,
  parameter int AW = 14
);
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] x_in;
  logic [XW-1:0] w_in;
  logic [1:0]    old_sel;
  logic [AW-1:0] old_val;
  logic [AW-1:0] acc_out;
  logic          busy;
  logic          done;

  // Environment side: issues start, streams x/w pairs and closes the mux loop.
  modport master (
    output start, in_valid, x_in, w_in, old_val,
    input  in_ready, old_sel, acc_out, busy, done
  );

  // MAC stage side.
  modport slave (
    input  start, in_valid, x_in, w_in, old_val,
    output in_ready, old_sel, acc_out, busy, done
  );
endinterface

// File: rtl/neuron_mac_ctrl.sv
// Sequential multiply-accumulate controller for one neuron. Loads the bias
// through the upstream mux, then accumulates N_INPUTS signed x*w products
// with the running sum fed back through the same mux, saturating at AW bits.
module neuron_mac_ctrl #(
  parameter int N_INPUTS = 4,
  parameter int XW       = 7,
  parameter int AW       = 14
) (
  input logic               clk,
  input logic               rst_n,
  neuron_mac_ctrl_if.slave  bus
);

  localparam int CW = $clog2(N_INPUTS) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_INPUTS - 1);
  // Saturation limits expressed at the widened sum width.
  localparam logic signed [AW:0] SAT_MAX = {2'b00, {(AW-1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {2'b11, {(AW-1){1'b0}}};

  localparam logic [1:0] SEL_BIAS = 2'b00;
  localparam logic [1:0] SEL_SUM  = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]          count_q, count_d;

  logic signed [2*XW-1:0] prod;
  logic signed [AW:0]     sum;
  logic signed [AW-1:0]   sum_sat;
  logic                   accept;

  // A pair is taken only while accumulating; in_ready itself is a pure state decode.
  assign accept = (state_q == ST_ACC) && bus.in_valid;

  // Full-precision product, widened sum and clamp to the AW-bit signed range.
  always_comb begin
    prod = $signed(bus.x_in) * $signed(bus.w_in);
    sum  = (AW+1)'($signed(bus.old_val)) + (AW+1)'(prod);
    if (sum > SAT_MAX) begin
      sum_sat = SAT_MAX[AW-1:0];
    end else if (sum < SAT_MIN) begin
      sum_sat = SAT_MIN[AW-1:0];
    end else begin
      sum_sat = sum[AW-1:0];
    end
  end

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_ACC;
      ST_ACC:  if (accept && (count_q == LAST_IDX)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Accumulator/count update: bias load in LOAD, saturated MAC on each accept.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    if (state_q == ST_LOAD) begin
      acc_d   = $signed(bus.old_val);
      count_d = '0;
    end else if (accept) begin
      acc_d   = sum_sat;
      count_d = count_q + CW'(1);
    end
  end

  // Output decode from state only, so the mux select never depends on in_valid.
  always_comb begin
    bus.old_sel  = SEL_ZERO;
    bus.busy     = 1'b0;
    bus.in_ready = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        bus.old_sel = SEL_BIAS;
        bus.busy    = 1'b1;
      end
      ST_ACC: begin
        bus.old_sel  = SEL_SUM;
        bus.busy     = 1'b1;
        bus.in_ready = 1'b1;
      end
      ST_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.acc_out = acc_q;

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Scoreboard bench for neuron_mac_ctrl: the stimulus task pushes hand-computed
// per-beat and final sums; independent monitors pop and compare on each
// accepted pair and on each done pulse.
module tb_neuron_mac_ctrl;
  localparam int N  = 4;
  localparam int XW = 7;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_mac_ctrl_if #(.XW(XW), .AW(AW)) bus ();

  neuron_mac_ctrl #(.N_INPUTS(N), .XW(XW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Upstream 3-to-1 mux model: bias, fed-back sum, or zero.
  logic [AW-1:0] bias_r = '0;
  assign bus.old_val = (bus.old_sel == 2'b00) ? bias_r :
                       (bus.old_sel == 2'b01) ? bus.acc_out : '0;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int done_cnt = 0;
  int beat_q[$];
  int done_q[$];

  int vx[N];
  int vw[N];
  int ve[N];
  int vg[N];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  // Per-beat monitor: an accept happens on the edge where in_valid && in_ready.
  initial begin : beat_mon
    bit fire;
    forever begin
      @(posedge clk);
      fire = rst_n && bus.in_valid && bus.in_ready;
      #1;
      if (fire) begin
        if (beat_q.size() == 0) begin
          n_vec = n_vec + 1; n_fail = n_fail + 1;
          $display("FAIL unexpected_accept: got acc %0d, expected no accept", $signed(bus.acc_out));
        end else begin
          chk("beat_acc", int'($signed(bus.acc_out)), beat_q.pop_front());
        end
      end
    end
  end

  // Result monitor: compares acc_out whenever done is presented.
  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cnt = done_cnt + 1;
        if (done_q.size() == 0) begin
          n_vec = n_vec + 1; n_fail = n_fail + 1;
          $display("FAIL unexpected_done: got done with acc %0d, expected none", $signed(bus.acc_out));
        end else begin
          chk("result", int'($signed(bus.acc_out)), done_q.pop_front());
        end
      end
    end
  end

  // One neuron evaluation from vx/vw/ve/vg. lat_exp: edges from the start
  // sampling edge to done (-1 skips). abort_at: assert reset after that many
  // accepts (-1 runs to completion).
  task automatic run_neuron(input int bias, input int lat_exp, input bit poke, input int abort_at);
    int t0, n0, seen;
    @(negedge clk);
    bias_r = AW'(bias);
    bus.start = 1'b1;
    if (abort_at < 0) done_q.push_back(ve[N-1]);
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc;
    n0 = done_cnt;
    chk("load_sel", int'(bus.old_sel), 0);
    chk("load_busy", int'(bus.busy), 1);
    chk("load_rdy", int'(bus.in_ready), 0);
    @(negedge clk);
    for (int b = 0; b < N; b++) begin
      for (int g = 0; g < vg[b]; g++) begin
        bus.in_valid = 1'b0;
        bus.start = poke;
        chk("gap_busy", int'(bus.busy), 1);
        @(negedge clk);
        bus.start = 1'b0;
      end
      chk("acc_sel", int'(bus.old_sel), 1);
      chk("acc_rdy", int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.x_in = XW'(vx[b]);
      bus.w_in = XW'(vw[b]);
      beat_q.push_back(ve[b]);
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (b + 1 == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_acc", int'($signed(bus.acc_out)), 0);
        chk("rst_sel", int'(bus.old_sel), 2);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_done_after_rst", done_cnt - n0, 0);
        chk("idle_sel_after_rst", int'(bus.old_sel), 2);
        return;
      end
    end
    seen = 0;
    for (int k = 0; k < 8 && seen == 0; k++) begin
      if (bus.done === 1'b1) seen = 1;
      else @(negedge clk);
    end
    chk("done_seen", seen, 1);
    if (seen == 1) begin
      if (lat_exp >= 0) chk("latency", cyc - t0, lat_exp);
      chk("done_sel", int'(bus.old_sel), 2);
      chk("done_busy", int'(bus.busy), 0);
    end
    @(negedge clk);
    chk("post_done", int'(bus.done), 0);
    chk("idle_sel", int'(bus.old_sel), 2);
    chk("hold_acc", int'($signed(bus.acc_out)), ve[N-1]);
    repeat (2) @(negedge clk);
    chk("done_once", done_cnt - n0, 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.x_in = '0;
    bus.w_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_acc", int'($signed(bus.acc_out)), 0);
    chk("reset_sel", int'(bus.old_sel), 2);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_rdy", int'(bus.in_ready), 0);
    chk("reset_done", int'(bus.done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic, 100 + 10+20+30+40 = 200; done N+1 edges after start sampling
    vx = '{1, 2, 3, 4};  vw = '{10, 10, 10, 10};
    ve = '{110, 130, 160, 200};  vg = '{0, 0, 0, 0};
    run_neuron(100, N + 1, 1'b0, -1);

    // 2: positive saturation, 8000 + 3969 clamps to 8191 and stays there
    vx = '{63, 1, 1, 1};  vw = '{63, 1, 1, 1};
    ve = '{8191, 8191, 8191, 8191};  vg = '{0, 0, 0, 0};
    run_neuron(8000, -1, 1'b0, -1);

    // 3: negative saturation, -8000 - 4032 clamps to -8192, then +1 per beat
    vx = '{-64, 1, 1, 1};  vw = '{63, 1, 1, 1};
    ve = '{-8192, -8191, -8190, -8189};  vg = '{0, 0, 0, 0};
    run_neuron(-8000, -1, 1'b0, -1);

    // 4: in_valid 1,0,0,1,1,0,1 with start pulsed in the bubbles
    vx = '{1, 2, 3, 4};  vw = '{10, 10, 10, 10};
    ve = '{110, 130, 160, 200};  vg = '{0, 2, 0, 1};
    run_neuron(100, -1, 1'b1, -1);

    // 5: reset after two accepts, then a clean run 0 + 4*(2*2) = 16
    vx = '{1, 2, 0, 0};  vw = '{10, 10, 0, 0};
    ve = '{110, 130, 0, 0};  vg = '{0, 0, 0, 0};
    run_neuron(100, -1, 1'b0, 2);
    vx = '{2, 2, 2, 2};  vw = '{2, 2, 2, 2};
    ve = '{4, 8, 12, 16};  vg = '{0, 0, 0, 0};
    run_neuron(0, N + 1, 1'b0, -1);

    // 6: extremes, (-64)*(-64) = 4096, then saturated at 8191
    vx = '{-64, -64, -64, -64};  vw = '{-64, -64, -64, -64};
    ve = '{4096, 8191, 8191, 8191};  vg = '{0, 0, 0, 0};
    run_neuron(0, N + 1, 1'b0, -1);

    repeat (3) @(negedge clk);
    chk("beat_q_empty", beat_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
endmodule
